ghost_collision: RTL
====================

Name: ghost_collision

Overview:
- Consumes the position/size triplets that a ghost block publishes (X, Y, half-size S, 10-bit each) and PacMan's triplet.
- Detects bounding-box overlap once per frame and debounces it.
- Sequences the resulting life-loss: hit pulse, freeze period, respawn, game over.
- Sits between the sprite position generators and game control. Game control uses freeze/respawn to halt and re-centre movers.

Parameters:
- START_LIVES, 3, lives loaded at reset and restart (1..7).
- CONFIRM_FRAMES, 2, consecutive overlapping frames required to register a hit (1..15).
- FREEZE_FRAMES, 60, frames spent frozen after a hit (1..255).
- INVULN_FRAMES, 120, post-respawn ignore window (used only with the optional feature, 1..255).

Ports:
- frame_clk  in  1  frame-rate clock; all state updates on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- pacX, pacY  in  10 each  PacMan centre.
- pacS  in  10  PacMan half-size.
- ghostX, ghostY  in  10 each  ghost centre.
- ghostS  in  10  ghost half-size.
- start  in  1  restart request; honoured only in OVER.
- hit  out  1  high for exactly the one HIT frame.
- freeze  out  1  high in HIT, FREEZE and OVER.
- respawn  out  1  one-frame pulse on each entry into PLAY from FREEZE or OVER.
- lives  out  3  remaining lives.
- game_over  out  1  high in OVER.

Behaviour:
- Overlap (combinational):
  - All arithmetic is 11-bit unsigned. dx = |pacX-ghostX|, dy = |pacY-ghostY|, lim = pacS+ghostS.
  - overlap = (dx < lim) && (dy < lim). The comparison is strict, so edges that only touch do not overlap.
- States: PLAY, HIT, FREEZE, OVER. All outputs are registered or decoded from state only.
- Reset (synchronous, highest priority, any state):
  - state=PLAY, lives=START_LIVES, ovl_cnt=0, frz_cnt=0.
  - hit=0, freeze=0, respawn=0, game_over=0.
- PLAY:
  - If overlap is low: ovl_cnt=0.
  - If overlap is high and ovl_cnt==CONFIRM_FRAMES-1: go to HIT, ovl_cnt=0.
  - Otherwise, while overlap is high: ovl_cnt increments.
  - Latency: the hit is registered on the edge after the CONFIRM_FRAMES-th consecutive overlapping frame.
- HIT (exactly 1 frame):
  - lives decrements at exit.
  - If lives==1: go to OVER (lives becomes 0).
  - Otherwise: go to FREEZE with frz_cnt=FREEZE_FRAMES-1.
- FREEZE:
  - Overlap is ignored.
  - frz_cnt decrements each frame. When frz_cnt==0: go to PLAY and assert respawn for that first PLAY frame.
  - ovl_cnt is cleared on entry to PLAY.
- OVER:
  - Holds indefinitely; start is sampled each frame.
  - When start=1: go to PLAY, lives=START_LIVES, respawn pulses.
  - start is ignored in all other states.
- Simultaneous events:
  - Reset beats start.
  - In the first PLAY frame after respawn, overlap is evaluated normally. Game control must have moved the sprites by then.
- lives never underflows; it saturates at 0 in OVER.

Optional Feature:
- Macro GHOST_COLLISION_INVULN_EN.
- Defined:
  - A 9-bit counter inv_cnt is loaded with INVULN_FRAMES on every respawn.
  - inv_cnt decrements each PLAY frame while nonzero.
  - While inv_cnt!=0, overlap is forced low (ovl_cnt stays 0).
  - Reset clears inv_cnt to 0.
- Not defined: the counter is absent and overlap is used directly.

Test Plan:
- Reset, pac (100,100,13), ghost (200,200,13) for 10 frames -> state PLAY, lives=3, hit/freeze/respawn/game_over all 0.
- Ghost (126,100): dx=26 equals lim -> no hit. Ghost (125,100) held 2 frames -> hit=1 on the following frame only; lives 3->2; freeze=1 for 1+60 frames; respawn=1 for one frame; freeze then drops.
- Ghost (125,100) for 1 frame, then (200,200), repeated -> never hits (debounce; ovl_cnt clears).
- Three confirmed hits -> lives 3->2->1->0, third HIT goes directly to OVER, game_over=1, freeze=1; start=1 -> lives=3, respawn pulse, game_over=0.
- Reset asserted mid-FREEZE (frame 30) together with start=1 -> next frame PLAY, lives=3, freeze=0, respawn=0.
- With GHOST_COLLISION_INVULN_EN: after respawn, continuous overlap -> no hit for 120 frames; hit registered on the 122nd PLAY frame (CONFIRM_FRAMES=2).

Source files
------------

// File: rtl/ghost_collision.sv
// ghost_collision: detects a debounced PacMan/ghost bounding-box overlap and sequences hit, freeze, respawn and game over.
// Optional feature: GHOST_COLLISION_INVULN_EN adds a post-respawn invulnerability window.
`default_nettype none

module ghost_collision #(
  parameter int START_LIVES    = 3,
  parameter int CONFIRM_FRAMES = 2,
  parameter int FREEZE_FRAMES  = 60,
  parameter int INVULN_FRAMES  = 120
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [9:0] pacX,
  input  logic [9:0] pacY,
  input  logic [9:0] pacS,
  input  logic [9:0] ghostX,
  input  logic [9:0] ghostY,
  input  logic [9:0] ghostS,
  input  logic       start,
  output logic       hit,
  output logic       freeze,
  output logic       respawn,
  output logic [2:0] lives,
  output logic       game_over
);

  typedef enum logic [1:0] {
    PLAY   = 2'd0,
    HIT    = 2'd1,
    FREEZE = 2'd2,
    OVER   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] lives_q, lives_d;
  logic [3:0] ovl_cnt_q, ovl_cnt_d;
  logic [7:0] frz_cnt_q, frz_cnt_d;
  logic       hit_q, hit_d;
  logic       freeze_q, freeze_d;
  logic       respawn_q, respawn_d;
  logic       game_over_q, game_over_d;

  logic [10:0] px, py, gx, gy;
  logic [10:0] dx, dy, lim;
  logic        overlap_raw, overlap;

`ifdef GHOST_COLLISION_INVULN_EN
  logic [8:0] inv_cnt_q, inv_cnt_d;
`endif

  always_comb begin
    px  = {1'b0, pacX};
    py  = {1'b0, pacY};
    gx  = {1'b0, ghostX};
    gy  = {1'b0, ghostY};
    dx  = (px >= gx) ? (px - gx) : (gx - px);
    dy  = (py >= gy) ? (py - gy) : (gy - py);
    lim = {1'b0, pacS} + {1'b0, ghostS};
    // Strict compare: boxes whose edges merely touch are not a collision.
    overlap_raw = (dx < lim) && (dy < lim);
`ifdef GHOST_COLLISION_INVULN_EN
    overlap = overlap_raw && (inv_cnt_q == 9'd0);
`else
    overlap = overlap_raw;
`endif
  end

  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    ovl_cnt_d = ovl_cnt_q;
    frz_cnt_d = frz_cnt_q;
    respawn_d = 1'b0;
`ifdef GHOST_COLLISION_INVULN_EN
    inv_cnt_d = inv_cnt_q;
`endif
    case (state_q)
      PLAY: begin
`ifdef GHOST_COLLISION_INVULN_EN
        if (inv_cnt_q != 9'd0) inv_cnt_d = inv_cnt_q - 9'd1;
`endif
        if (!overlap) begin
          ovl_cnt_d = 4'd0;
        end else if (ovl_cnt_q == 4'(CONFIRM_FRAMES - 1)) begin
          state_d   = HIT;
          ovl_cnt_d = 4'd0;
        end else begin
          ovl_cnt_d = ovl_cnt_q + 4'd1;
        end
      end
      HIT: begin
        if (lives_q != 3'd0) lives_d = lives_q - 3'd1;
        if (lives_q <= 3'd1) begin
          state_d = OVER;
        end else begin
          state_d   = FREEZE;
          frz_cnt_d = 8'(FREEZE_FRAMES - 1);
        end
      end
      FREEZE: begin
        if (frz_cnt_q == 8'd0) begin
          state_d   = PLAY;
          ovl_cnt_d = 4'd0;
          respawn_d = 1'b1;
        end else begin
          frz_cnt_d = frz_cnt_q - 8'd1;
        end
      end
      OVER: begin
        if (start) begin
          state_d   = PLAY;
          lives_d   = 3'(START_LIVES);
          ovl_cnt_d = 4'd0;
          respawn_d = 1'b1;
        end
      end
      default: state_d = PLAY;
    endcase
`ifdef GHOST_COLLISION_INVULN_EN
    if (respawn_d) inv_cnt_d = 9'(INVULN_FRAMES);
`endif
    // Outputs are decoded from the next state so they line up with the state register.
    hit_d       = (state_d == HIT);
    freeze_d    = (state_d != PLAY);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q     <= PLAY;
      lives_q     <= 3'(START_LIVES);
      ovl_cnt_q   <= 4'd0;
      frz_cnt_q   <= 8'd0;
      hit_q       <= 1'b0;
      freeze_q    <= 1'b0;
      respawn_q   <= 1'b0;
      game_over_q <= 1'b0;
`ifdef GHOST_COLLISION_INVULN_EN
      inv_cnt_q   <= 9'd0;
`endif
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      ovl_cnt_q   <= ovl_cnt_d;
      frz_cnt_q   <= frz_cnt_d;
      hit_q       <= hit_d;
      freeze_q    <= freeze_d;
      respawn_q   <= respawn_d;
      game_over_q <= game_over_d;
`ifdef GHOST_COLLISION_INVULN_EN
      inv_cnt_q   <= inv_cnt_d;
`endif
    end
  end

  assign hit       = hit_q;
  assign freeze    = freeze_q;
  assign respawn   = respawn_q;
  assign lives     = lives_q;
  assign game_over = game_over_q;

endmodule

`default_nettype wire
